// File: rtl/reset_seq.sv
// reset_seq: staged reset sequencer for the board clock domain.
// Waits for a synchronised DCM/PLL lock, lets it settle for WAIT_CYCLES,
// then releases rst_o[0..N_RST-1] one at a time, STAGE_GAP cycles apart.
// Loss of lock or a software request re-asserts every reset at once;
// loss of lock is also recorded in a sticky flag and a saturating counter.
// Optional feature macro: RSTSEQ_LOCK_FILTER_EN adds a FILTER_LEN-cycle
// debounce on the rising edge of the synchronised lock.
// Handshake: none; every output is a registered level, valid every cycle.
module reset_seq #(
  parameter int N_RST       = 3,
  parameter int WAIT_CYCLES = 15,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             locked_i,
  input  logic             soft_rst_i,
  input  logic             lock_lost_clr_i,
  output logic [N_RST-1:0] rst_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] lost_cnt_o
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int STG_W  = (N_RST > 1) ? $clog2(N_RST) : 1;

  // Elaboration-time parameter sanity checks
  if (N_RST < 1 || WAIT_CYCLES < 1 || STAGE_GAP < 1 || CNT_W < 1 || FILTER_LEN < 1) begin : g_param_chk
    $error("reset_seq: N_RST, WAIT_CYCLES, STAGE_GAP, CNT_W and FILTER_LEN must all be >= 1");
  end

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_REL  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [N_RST-1:0]   rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic               lk;

  // Two-flop synchroniser for the asynchronous LOCKED input
  always_comb begin
    sync1_d = locked_i;
    sync2_d = sync1_q;
  end

`ifdef RSTSEQ_LOCK_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  logic [FLT_W-1:0] flt_q, flt_d;

  // Debounce: lock counts as good only after FILTER_LEN consecutive high samples; fall is immediate
  always_comb begin
    flt_d = flt_q;
    if (!sync2_q) begin
      flt_d = '0;
    end else if (flt_q != FLT_W'(FILTER_LEN)) begin
      flt_d = flt_q + FLT_W'(1);
    end
  end

  assign lk = sync2_q && (flt_q == FLT_W'(FILTER_LEN));

  // Filter counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) flt_q <= '0;
    else       flt_q <= flt_d;
  end
`else
  assign lk = sync2_q;
`endif

  // Events that abort the sequence from any non-HOLD state
  logic loss_evt, soft_evt, abort;
  logic wait_done, gap_done, last_stage;

  assign loss_evt   = (state_q != ST_HOLD) && !lk;
  assign soft_evt   = (state_q != ST_HOLD) && soft_rst_i;
  assign abort      = loss_evt || soft_evt;
  assign wait_done  = (state_q == ST_WAIT) && (cnt_q == WAIT_W'(WAIT_CYCLES - 1));
  assign gap_done   = (state_q == ST_REL) && (gap_q == GAP_W'(STAGE_GAP - 1));
  assign last_stage = (stage_q == STG_W'(N_RST - 1));

  // State register and all other flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      stage_q     <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      stage_q     <= stage_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  // Next-state logic: HOLD -> WAIT -> REL -> RUN, any abort returns to HOLD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    case (state_q)
      ST_HOLD: begin
        if (lk && !soft_rst_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + WAIT_W'(1);
        if (wait_done) begin
          if (N_RST == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_REL;
            stage_d = STG_W'(1);
            gap_d   = '0;
          end
        end
      end
      ST_REL: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_done) begin
          gap_d   = '0;
          stage_d = stage_q + STG_W'(1);
          if (last_stage) state_d = ST_RUN;
        end
      end
      default: ;
    endcase
    if (abort) state_d = ST_HOLD;
  end

  // Output logic: release one reset bit per stage, re-assert all on abort, track lock loss
  always_comb begin
    rst_d       = rst_q;
    ready_d     = ready_q;
    lock_lost_d = lock_lost_q;
    lost_cnt_d  = lost_cnt_q;
    if (wait_done) begin
      rst_d[0] = 1'b0;
      if (N_RST == 1) ready_d = 1'b1;
    end
    if (gap_done) begin
      for (int i = 0; i < N_RST; i++) begin
        if (int'(stage_q) == i) rst_d[i] = 1'b0;
      end
      if (last_stage) ready_d = 1'b1;
    end
    if (abort) begin
      rst_d   = '1;
      ready_d = 1'b0;
    end
    if (loss_evt) begin
      lock_lost_d = 1'b1;
      if (lost_cnt_q != '1) lost_cnt_d = lost_cnt_q + CNT_W'(1);
    end else if (lock_lost_clr_i) begin
      lock_lost_d = 1'b0;
    end
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;
  assign lost_cnt_o  = lost_cnt_q;

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised reset sequencer for the board clock domain; successor to the single-output lock-wait reset generator in the clocks module.
- Takes the DCM/PLL LOCKED status, waits a programmable settle time, then releases N_RST reset outputs one at a time with a programmable gap.
- Adds loss-of-lock re-arming, a software reset request and lock-loss diagnostics.
- Sits downstream of the DCM and drives the per-subsystem resets (system, UART, peripherals).

Parameters:
N_RST, 3, number of staged reset outputs (>=1)
WAIT_CYCLES, 15, settle cycles after lock before the first release (>=1)
STAGE_GAP, 4, cycles between successive releases (>=1)
CNT_W, 8, width of the lock-loss counter
FILTER_LEN, 8, lock debounce length; used only when RSTSEQ_LOCK_FILTER_EN is defined (>=1)

Ports:
clk_i  in  1  sequencer clock (BUFG output); all logic on posedge
rst_i  in  1  reset; synchronous, active-high
locked_i  in  1  DCM LOCKED; asynchronous to clk_i
soft_rst_i  in  1  software reset request, level-sensitive
lock_lost_clr_i  in  1  clears lock_lost_o
rst_o  out  N_RST  staged resets, active-high; bit 0 released first
ready_o  out  1  high when all resets are released
lock_lost_o  out  1  sticky flag: lock was lost after the sequence started
lost_cnt_o  out  CNT_W  saturating count of lock-loss events

Behaviour:
- rst_i=1 at a posedge: rst_o=all ones, ready_o=0, lock_lost_o=0, lost_cnt_o=0, state HOLD, all counters and synchroniser flops = 0. rst_i overrides every other input, including mid-sequence.
- locked_i passes through a 2-FF synchroniser to give lk.
- HOLD: rst_o all ones. If lk=1 and soft_rst_i=0, go to WAIT with cnt=0.
- WAIT: cnt increments each cycle. At the edge where cnt==WAIT_CYCLES-1, go to REL, clear rst_o[0] and set stage=1 with gap=0.
- REL: gap increments each cycle. At the edge where gap==STAGE_GAP-1, clear rst_o[stage], increment stage and set gap=0. Clearing rst_o[N_RST-1] moves to RUN and sets ready_o=1 on the same edge.
- N_RST=1: WAIT goes directly to RUN.
- Release timing, with E0 = first edge that samples locked_i=1 and no filter: rst_o[k] falls at E(2+WAIT_CYCLES+k*STAGE_GAP).
- Lock loss: lk=0 in WAIT, REL or RUN. On the next edge: rst_o all ones, ready_o=0, go to HOLD, lock_lost_o=1, lost_cnt_o increments and saturates at all ones. lk=0 in HOLD is not an event.
- Soft reset: soft_rst_i=1 in WAIT, REL or RUN gives the same reset action as lock loss, but flags and counter are untouched. Holding soft_rst_i keeps the block in HOLD.
- Lock loss and soft reset in the same cycle: counts as a lock loss.
- lock_lost_clr_i=1 clears lock_lost_o next edge. A lock-loss event in the same cycle wins, and the flag stays 1.
- rst_o bits are released strictly in order and never glitch low. Any re-assert sets all bits at once.
- All outputs are registered.

Optional Feature:
RSTSEQ_LOCK_FILTER_EN
- Defined: lk rises only after the synchronised lock has been high for FILTER_LEN consecutive cycles. Any low sample restarts the filter. Fall is immediate (the reset asserts fast). Release times shift by +FILTER_LEN cycles.
- Not defined: lk is the 2-FF synchroniser output; FILTER_LEN is unused and no filter logic is instantiated.

Test Plan:
- Defaults, no filter; rst_i pulse, then locked_i=1 from E0 -> rst_o[0] falls at E17, rst_o[1] at E21, rst_o[2] and ready_o=1 at E25.
- In RUN, locked_i low for 1 cycle -> 3 edges later rst_o=3'b111, ready_o=0, lock_lost_o=1, lost_cnt_o=1; full re-sequence follows once lock returns.
- soft_rst_i held 5 cycles during REL -> rst_o=3'b111, lock_lost_o and lost_cnt_o unchanged; sequence restarts after release, rst_o[0] falls WAIT_CYCLES+1 edges after soft_rst_i drops.
- 300 lock-loss events with CNT_W=8 -> lost_cnt_o saturates at 255; lock_lost_clr_i asserted in the same cycle as a loss event -> lock_lost_o stays 1.
- rst_i asserted mid-REL -> next edge all outputs at reset values and lost_cnt_o=0.
- RSTSEQ_LOCK_FILTER_EN, FILTER_LEN=8: lock bouncing with 5-cycle highs -> rst_o stays all ones; stable lock -> rst_o[0] falls at E25.
